// File: rtl/fifo_uart_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fifo_uart_pkg
// Purpose  : Shared definitions for the FIFO-fed UART transmitter: frame
//            geometry, the default bit period and the controller state
//            encoding.
// Config   : FIFO_UART_TX_PARITY_EN adds the PARITY state to the encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package fifo_uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int STATE_W          = 3;

    // Explicit encodings keep the state register width fixed whether or not
    // the parity state is present.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY = 3'd5,
`endif
        ST_STOP   = 3'd6
    } state_t;

endpackage : fifo_uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : uart_baud_gen
// Purpose  : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the
//            terminal count; clear restarts the period from zero.
// Ports    : clk   - clock
//            rst   - synchronous active-high reset
//            clear - restart the period (asserted on every state change)
//            tick  - high on the last cycle of a bit period
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module uart_baud_gen
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] c_TERM = 16'(CLKS_PER_BIT - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= 16'd0;
        end else if (r_cnt == c_TERM) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign tick = (r_cnt == c_TERM);

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fifo_uart_tx
// Purpose  : Pulls one byte at a time from a FIFO and sends it as an 8N1
//            (or 8E1) UART frame, LSB first.
// Ports    : clk      - clock
//            rst      - synchronous active-high reset
//            Fempty   - FIFO empty flag (sampled only while idle)
//            Dout     - FIFO read data, valid the cycle after an accepted read
//            fifo_wen - FIFO write enable monitor; a read in that cycle is lost
//            Ren      - FIFO read enable (registered, high while fetching)
//            txd      - serial output, idles high
//            busy     - frame in progress (fetch through stop)
//            done     - one-cycle pulse on the last stop-bit cycle
// Config   : FIFO_UART_TX_PARITY_EN inserts an even-parity bit before stop.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Fempty,
    input  logic [7:0] Dout,
    input  logic       fifo_wen,
    output logic       Ren,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [2:0]             r_bit;
    logic                   r_ren;
    logic                   w_tick;
    logic                   w_clear;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                   r_parity;
`endif

    // Every state entry restarts the bit period so each state owns a full
    // CLKS_PER_BIT window from its first cycle.
    assign w_clear = (w_next != r_state);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    //--------------------------------------------------------------------------
    // State and datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ren    <= 1'b0;
            r_shift  <= '0;
            r_bit    <= 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            // Registered read enable that tracks the FETCH state exactly,
            // including retries while the FIFO is being written.
            r_ren   <= (w_next == ST_FETCH);
            case (r_state)
                ST_LOAD: begin
                    r_shift  <= Dout;
                    r_bit    <= 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
                    // Captured here because the shift register is consumed
                    // while the data bits go out.
                    r_parity <= ^Dout;
`endif
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        txd    = 1'b1;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (!Fempty) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // A read issued while the FIFO is writing is ignored by the
                // FIFO, so hold Ren and try again.
                if (!fifo_wen) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_next = ST_START;
            end
            ST_START: begin
                txd = 1'b0;
                if (w_tick) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                txd = r_shift[0];
                if (w_tick && (r_bit == c_LAST_BIT)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    w_next = ST_PARITY;
`else
                    w_next = ST_STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                txd = r_parity;
                if (w_tick) begin
                    w_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    done   = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    assign Ren = r_ren;

endmodule : fifo_uart_tx
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_fifo_uart_tx
// Purpose  : Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4. A
//            behavioural FIFO feeds the DUT; the serial line, Ren, busy and
//            done are recorded and compared against frames built from the
//            bytes written.
// Config   : FIFO_UART_TX_PARITY_EN selects the 11-bit frame expectation.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Fempty = 1'b1;
    logic [7:0] Dout = 8'h00;
    logic       fifo_wen = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       Ren, txd, busy, done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .Fempty   (Fempty),
        .Dout     (Dout),
        .fifo_wen (fifo_wen),
        .Ren      (Ren),
        .txd      (txd),
        .busy     (busy),
        .done     (done)
    );

    // Behavioural FIFO: a write wins over a read in the same cycle.
    logic [7:0] fq[$];
    int         rd_cnt = 0;
    always @(posedge clk) begin
        if (fifo_wen) begin
            fq.push_back(wr_data);
        end else if (Ren && fq.size() > 0) begin
            Dout <= fq.pop_front();
            rd_cnt++;
        end
        Fempty <= (fq.size() == 0);
    end

    // Output recorder
    logic rec_on = 1'b0;
    logic rec_txd[$];
    logic rec_ren[$];
    logic rec_busy[$];
    logic rec_done[$];
    always @(negedge clk) begin
        if (rec_on) begin
            rec_txd.push_back(txd);
            rec_ren.push_back(Ren);
            rec_busy.push_back(busy);
            rec_done.push_back(done);
        end
    end

    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        wr_data  = b;
        fifo_wen = 1'b1;
        exp_q.push_back(b);
        @(negedge clk);
        fifo_wen = 1'b0;
    endtask

    task automatic rec_start();
        rec_txd.delete(); rec_ren.delete(); rec_busy.delete(); rec_done.delete();
        exp_q.delete();
        rec_on = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (!(busy == 1'b0 && Fempty == 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk({tag, "_idle_timeout"}, 0, 1);
        tick_n(4);
        rec_on = 1'b0;
        @(negedge clk);
    endtask

    // Expected line levels for one frame: start, data LSB first,
    // optional even parity, stop.
    function automatic logic [11:0] frame_of(input logic [7:0] b);
        logic [11:0] v;
        v = '0;
        v[0] = 1'b0;
        for (int k = 0; k < 8; k++) v[1 + k] = b[k];
        if (NB == 11) v[9] = ($countones(b) % 2 == 1);
        v[NB - 1] = 1'b1;
        return v;
    endfunction

    function automatic int count_ones(input logic q[$]);
        int c = 0;
        foreach (q[i]) if (q[i]) c++;
        return c;
    endfunction

    function automatic int first_idx(input logic q[$], input logic val);
        for (int i = 0; i < q.size(); i++) if (q[i] == val) return i;
        return -1;
    endfunction

    // Walks the recording frame by frame against the bytes in exp_q.
    task automatic analyze(input string tag);
        int pos = 0;
        int prev_end = -1;
        int s;
        int zeros;
        logic [11:0] ov, ev;
        logic stable;
        for (int f = 0; f < exp_q.size(); f++) begin
            s = -1;
            for (int i = pos; i < rec_txd.size(); i++) begin
                if (rec_txd[i] == 1'b0) begin s = i; break; end
            end
            if (s < 0 || s + NB * CPB > rec_txd.size()) begin
                chk({tag, "_frame_present"}, 0, 1);
                return;
            end
            ev = frame_of(exp_q[f]);
            ov = '0;
            stable = 1'b1;
            for (int k = 0; k < NB; k++) begin
                ov[k] = rec_txd[s + k * CPB + CPB / 2];
                for (int c = 0; c < CPB; c++)
                    if (rec_txd[s + k * CPB + c] !== ov[k]) stable = 1'b0;
            end
            chk({tag, "_bits"}, int'(ov), int'(ev));
            chk({tag, "_bit_width"}, int'(stable), 1);
            chk({tag, "_done_pos"}, int'(rec_done[s + NB * CPB - 1]), 1);
            if (prev_end >= 0) chk({tag, "_gap"}, s - prev_end, 3);
            prev_end = s + NB * CPB;
            pos = prev_end;
        end
        zeros = 0;
        for (int i = pos; i < rec_txd.size(); i++) if (rec_txd[i] == 1'b0) zeros++;
        chk({tag, "_no_extra_frame"}, zeros, 0);
        chk({tag, "_done_count"}, count_ones(rec_done), exp_q.size());
    endtask

    initial begin
        int rd0, r, s, n, run;
        logic [7:0] b;

        // Reset state
        rst = 1'b1;
        tick_n(3);
        chk("reset_ren", int'(Ren), 0);
        chk("reset_txd", int'(txd), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        tick_n(2);

        // Single byte 0xA5
        rec_start();
        rd0 = rd_cnt;
        tick_n(2);
        push(8'hA5);
        wait_idle("a5");
        analyze("a5");
        chk("a5_ren_cycles", count_ones(rec_ren), 1);
        chk("a5_reads", rd_cnt - rd0, 1);
        r = first_idx(rec_ren, 1'b1);
        s = first_idx(rec_txd, 1'b0);
        chk("a5_ren_to_start", s - r, 2);
        chk("a5_busy_rise", first_idx(rec_busy, 1'b1), r);
        chk("a5_busy_end", int'(rec_busy[rec_busy.size() - 1]), 0);

        // Single byte 0x01 (odd parity data)
        rec_start();
        push(8'h01);
        wait_idle("b01");
        analyze("b01");

        // Back-to-back 0x3C, 0xC3
        rec_start();
        rd0 = rd_cnt;
        push(8'h3C);
        push(8'hC3);
        wait_idle("b2b");
        analyze("b2b");
        chk("b2b_reads", rd_cnt - rd0, 2);
        chk("b2b_ren_cycles", count_ones(rec_ren), 2);

        // Write collision during FETCH: two writes hold the read off
        rec_start();
        rd0 = rd_cnt;
        push(8'h96);
        n = 0;
        while (Ren !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("wen_fetch_timeout", 0, 1);
        push(8'($urandom));
        push(8'($urandom));
        wait_idle("wen");
        analyze("wen");
        r = first_idx(rec_ren, 1'b1);
        run = 0;
        if (r >= 0) while (r + run < rec_ren.size() && rec_ren[r + run]) run++;
        chk("wen_ren_run", run, 3);
        chk("wen_reads", rd_cnt - rd0, 3);
        chk("wen_ren_cycles", count_ones(rec_ren), 5);

        // Random burst
        rec_start();
        for (int i = 0; i < 5; i++) push(8'($urandom));
        wait_idle("rand");
        analyze("rand");

        // Reset during data bit 4
        exp_q.delete();
        rd0 = rd_cnt;
        push(8'($urandom));
        n = 0;
        while (txd !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("rst_start_timeout", 0, 1);
        tick_n(CPB + 4 * CPB + 1);
        rst = 1'b1;
        tick_n(1);
        rst = 1'b0;
        chk("rst_mid_txd", int'(txd), 1);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ren", int'(Ren), 0);
        rec_start();
        tick_n(30);
        rec_on = 1'b0;
        @(negedge clk);
        chk("rst_no_ren", count_ones(rec_ren), 0);
        chk("rst_line_idle", first_idx(rec_txd, 1'b0), -1);
        chk("rst_reads", rd_cnt - rd0, 1);

        // Recovery after abort
        rec_start();
        b = 8'($urandom);
        push(b);
        wait_idle("post_rst");
        analyze("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_uart_tx
`default_nettype wire

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit period; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 Fempty  input  1  FIFO empty flag, driven from the FIFO read side.
REQ-005 Dout  input  8  FIFO read data; valid from the cycle after the FIFO accepts a read.
REQ-006 fifo_wen  input  1  monitor of the FIFO write enable; when high, the FIFO ignores a read that cycle.
REQ-007 Ren  output  1  FIFO read enable, registered.
REQ-008 txd  output  1  serial line; idle level 1.
REQ-009 busy  output  1  high from FETCH entry until STOP completes.
REQ-010 done  output  1  one-cycle pulse on the last STOP cycle.

Function
REQ-011 States SHALL be IDLE, FETCH, LOAD, START, DATA, PARITY (macro-gated), STOP.
REQ-012 In IDLE with Fempty=0, the next state SHALL be FETCH; with Fempty=1, the block SHALL remain in IDLE.
REQ-013 Ren SHALL be 1 exactly while in FETCH.
REQ-014 In FETCH, if fifo_wen=1 the block SHALL stay in FETCH, keeping Ren=1 (read retried); otherwise the next state SHALL be LOAD.
REQ-015 In LOAD, the block SHALL capture Dout into an 8-bit shift register, then go to START.
REQ-016 In START, txd SHALL be 0 for CLKS_PER_BIT cycles.
REQ-017 DATA SHALL send 8 bits LSB first, each bit for CLKS_PER_BIT cycles, with a 3-bit bit index counting 0..7.
REQ-018 In STOP, txd SHALL be 1 for CLKS_PER_BIT cycles, with done=1 on the final cycle, then the next state SHALL be IDLE.
REQ-019 Bit-period counter SHALL be 16 bits wide, reset to 0 on every state entry, and SHALL advance on terminal count CLKS_PER_BIT-1.
REQ-020 Back-to-back: with Fempty=0 at STOP end, the next state SHALL be IDLE, then FETCH on the following cycle; the inter-frame gap from stop end to start SHALL be exactly 3 cycles (IDLE, FETCH, LOAD).
REQ-021 Fempty SHALL be sampled only in IDLE; changes during a frame SHALL be ignored.
REQ-022 Only one byte SHALL be read per frame; Ren SHALL never be high for more than one accepted cycle per frame.

Reset
REQ-023 While rst=1 at posedge: state=IDLE, Ren=0, txd=1, busy=0, done=0, counters=0, shift register=0.
REQ-024 rst mid-frame SHALL abort the frame immediately (txd=1 next cycle); the aborted byte SHALL be lost, not re-read.

Configuration
REQ-025 Macro FIFO_UART_TX_PARITY_EN: when defined, PARITY SHALL follow DATA, sending the even-parity bit (XOR of 8 data bits) for CLKS_PER_BIT cycles, then STOP; when undefined, DATA SHALL go directly to STOP and PARITY SHALL not exist in the state encoding.

Structure
REQ-026 Shared package fifo_uart_pkg SHALL hold the state encoding constants, DATA_BITS=8, and the CLKS_PER_BIT default.
REQ-027 Bit-period counting SHALL be in sub-module uart_baud_gen (inputs clk, rst, clear; output tick).

Verification (CLKS_PER_BIT=4)
REQ-028 FIFO holds 0xA5, no parity -> Ren high one cycle; txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done pulses once; busy low after.
REQ-029 0xA5 with FIFO_UART_TX_PARITY_EN -> parity bit 0 between data and stop; 0x01 -> parity bit 1.
REQ-030 Bytes 0x3C, 0xC3 queued -> two frames, 3-cycle gap of txd=1 between stop end and second start bit; Fempty=1 after the second read.
REQ-031 fifo_wen=1 for 2 cycles during FETCH -> Ren held 3 cycles, single read accepted; byte sent intact.
REQ-032 rst pulsed during DATA bit 4 -> txd=1, busy=0, Ren=0 next cycle; no further Ren until Fempty=0 sampled in IDLE.
